// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types for the instruction-fetch controller.
package ifetch_pkg;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} ifetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/ifetch_ctrl_fetch_buf.sv
// fetch_buf: small FIFO of PC-tagged fetch entries; flush wins over push.
module fetch_buf
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             entry,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem    <= '{default: '0};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: PC sequencing, credit-based imem issue, redirect/halt/fault handling.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 65536,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        halt_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_rden_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        fault_o,
    output logic [31:0] fault_pc_o,
    output logic [31:0] fetch_cnt_o
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = BUF_DEPTH[CW:0];

    ifetch_state_e  state_q, state_d;
    logic [31:0]    pc_q, inflight_pc_q, fault_pc_q, cnt_q;
    logic           inflight_q, fault_q;
    logic [CW-1:0]  count;
    logic [CW:0]    occ;
    fetch_entry_t   head;
    logic           redir, redir_bad, pc_ok, pop, push, flush, run_ok, issue, seq_bad;

    assign redir     = redirect_i && (state_q == RUN || state_q == HALT);
    assign redir_bad = redir && (redirect_pc_i[1:0] != 2'b00 || redirect_pc_i >= IMEM_BYTES);
    assign pc_ok     = pc_q < IMEM_BYTES;
    assign pop       = instr_valid_o && instr_ready_i;
    assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    assign flush     = redir || seq_bad;
    assign push      = inflight_q && !flush;

    // A sequential overrun only faults once older fetches have drained, so they reach decode first.
    always_comb begin
        run_ok  = state_q == RUN && !halt_i && !redir;
        issue   = run_ok && pc_ok && occ < DEPTH_C;
        seq_bad = run_ok && !pc_ok && count == '0 && !inflight_q;
        state_d = state_q == BOOT ? RUN :
                  (redir_bad || seq_bad) ? FAULT :
                  state_q == FAULT ? FAULT :
                  halt_i ? HALT : RUN;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= BOOT;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
            cnt_q         <= '0;
        end else begin
            pc_q          <= (redir && !redir_bad) ? redirect_pc_i : issue ? pc_q + 32'd4 : pc_q;
            inflight_q    <= issue;
            inflight_pc_q <= issue ? pc_q : inflight_pc_q;
            cnt_q         <= cnt_q + {31'd0, pop};
            if (redir_bad || seq_bad) begin
                fault_q    <= 1'b1;
                fault_pc_q <= redir_bad ? redirect_pc_i : pc_q;
            end
        end
    end

    fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .entry  ('{pc: inflight_pc_q, instr: imem_data_i}),
        .head   (head),
        .count  (count)
    );

    assign imem_rden_o   = issue;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = state_q != FAULT && count != '0;
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;
    assign fault_o       = fault_q;
    assign fault_pc_o    = fault_pc_q;
    assign fetch_cnt_o   = cnt_q;
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed scoreboard bench for ifetch_ctrl with a 1-cycle imem model.
module tb_ifetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        rden;
    logic [31:0] addr;
    logic [31:0] imem_data = '0;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        ready = 1'b0;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_cnt;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ifetch_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .halt_i        (halt),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_rden_o   (rden),
        .imem_addr_o   (addr),
        .imem_data_i   (imem_data),
        .instr_valid_o (valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_ready_i (ready),
        .fault_o       (fault),
        .fault_pc_o    (fault_pc),
        .fetch_cnt_o   (fetch_cnt)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    always @(posedge clk) if (rden) imem_data <= word(addr);

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", n, a, x);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_accept actual_pc=%h expected=none", instr_pc);
            end else begin
                e = exp_q.pop_front();
                chk("accept_pc", instr_pc, e);
                chk("accept_instr", instr, word(e));
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ready = rdy;
        halt = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        exp_q.delete();
        smp();
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_rden", {31'd0, rden}, 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_fault_pc", fault_pc, 32'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        next();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int oob;
        // streaming from reset with decode always ready
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
        smp();
        chk("boot_rden", {31'd0, rden}, 32'd0);
        chk("boot_valid", {31'd0, valid}, 32'd0);
        next(); smp();
        chk("c1_rden", {31'd0, rden}, 32'd1);
        chk("c1_addr", addr, 32'h0);
        next(); smp();
        chk("c2_valid", {31'd0, valid}, 32'd0);
        next(); smp();
        chk("c3_valid", {31'd0, valid}, 32'd1);
        repeat (9) begin next(); smp(); end
        next();
        ready = 1'b0;
        smp();
        chk("stream_cnt", fetch_cnt, 32'd10);
        chk("stream_drain", exp_q.size(), 32'd0);

        // backpressure: buffer fills, head holds, then resumes without gaps
        do_reset(1'b0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        repeat (3) next();
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("hold_valid", {31'd0, valid}, 32'd1);
            chk("hold_pc", instr_pc, 32'h0);
            chk("hold_rden", {31'd0, rden}, 32'd0);
            next();
        end
        ready = 1'b1;
        smp(); chk("resume_valid8", {31'd0, valid}, 32'd1);
        next(); smp(); chk("resume_valid9", {31'd0, valid}, 32'd1);
        next(); smp(); chk("resume_valid10", {31'd0, valid}, 32'd1);
        chk("resume_addr10", addr, 32'h10);

        // redirect while PC 12 is buffered and PC 16 is in flight
        next();
        ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(i * 4));
        smp();
        chk("redir_head_pc", instr_pc, 32'hC);
        chk("redir_cnt", fetch_cnt, 32'd3);
        next();
        redirect = 1'b0;
        ready = 1'b1;
        smp();
        chk("redir_r1_valid", {31'd0, valid}, 32'd0);
        chk("redir_r1_rden", {31'd0, rden}, 32'd1);
        chk("redir_r1_addr", addr, 32'h100);
        next(); smp();
        chk("redir_r2_valid", {31'd0, valid}, 32'd0);
        next(); smp();
        chk("redir_r3_valid", {31'd0, valid}, 32'd1);
        chk("redir_r3_pc", instr_pc, 32'h100);

        // halt for 4 cycles: no fetches, buffered words still drain
        next();
        halt = 1'b1;
        smp();
        chk("halt_rden", {31'd0, rden}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            next(); smp();
            chk("halt_rden", {31'd0, rden}, 32'd0);
        end
        chk("halt_cnt", fetch_cnt, 32'd6);
        next();
        halt = 1'b0;
        for (int i = 0; i < 12; i++) begin
            smp();
            if (exp_q.size() == 0) break;
            next();
        end
        next();
        ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h102;
        smp();
        chk("halt_resume_cnt", fetch_cnt, 32'd7);
        chk("halt_drain", exp_q.size(), 32'd0);

        // misaligned redirect faults; later redirects are ignored
        next();
        redirect = 1'b0;
        smp();
        chk("fault_o", {31'd0, fault}, 32'd1);
        chk("fault_pc", fault_pc, 32'h102);
        chk("fault_valid", {31'd0, valid}, 32'd0);
        chk("fault_rden", {31'd0, rden}, 32'd0);
        next();
        redirect = 1'b1;
        redirect_pc = 32'h0;
        ready = 1'b1;
        next();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("fault_sticky", {31'd0, fault}, 32'd1);
            chk("fault_sticky_pc", fault_pc, 32'h102);
            chk("fault_sticky_valid", {31'd0, valid}, 32'd0);
            chk("fault_sticky_rden", {31'd0, rden}, 32'd0);
            next();
        end

        // sequential fetch runs off the end of instruction memory
        do_reset(1'b1);
        next();
        redirect = 1'b1;
        redirect_pc = 32'hFFF0;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hFFF0 + 32'(i * 4));
        next();
        redirect = 1'b0;
        oob = 0;
        for (int i = 0; i < 30; i++) begin
            smp();
            if (rden && addr >= 32'h10000) oob++;
            if (fault) break;
            next();
        end
        chk("seq_fault", {31'd0, fault}, 32'd1);
        chk("seq_fault_pc", fault_pc, 32'h10000);
        chk("seq_fault_valid", {31'd0, valid}, 32'd0);
        chk("seq_fault_rden", {31'd0, rden}, 32'd0);
        chk("seq_oob_rden", 32'(oob), 32'd0);
        chk("seq_cnt", fetch_cnt, 32'd4);
        chk("seq_drain", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
